// File: rtl/temporal_interval.sv
// temporal_interval
//   Resolves one score interval of flexible duration [dmin, dmax], measured in
//   rising edges of the divided time base `tick`. The interval ends when an
//   interactive trigger arrives inside the window, or by timeout at dmax.
//
// Ports
//   clk          system clock (same clock as the upstream clock_divider)
//   rst          synchronous, active-high reset
//   tick         divided time base, level signal synchronous to clk
//   start        one-cycle request to begin an interval (IDLE only)
//   abort        cancel a running interval without producing fire
//   trigger      interactive event, one-cycle pulse
//   dmin, dmax   duration bounds in ticks, latched on an accepted start
//   busy         interval running (WAIT_MIN or WINDOW)
//   in_window    state is WINDOW
//   elapsed      ticks counted since start; holds after completion
//   fire         one-cycle pulse when the interval ends
//   fire_timeout qualifies fire: 1 = ended by timeout (0 when fire is 0)
//   early        one-cycle pulse for a discarded trigger in WAIT_MIN
//   param_err    one-cycle pulse for a rejected start with dmin > dmax
module temporal_interval #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic             trigger,
  input  logic [WIDTH-1:0] dmin,
  input  logic [WIDTH-1:0] dmax,
  output logic             busy,
  output logic             in_window,
  output logic [WIDTH-1:0] elapsed,
  output logic             fire,
  output logic             fire_timeout,
  output logic             early,
  output logic             param_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MIN = 2'd1,
    WINDOW   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             tick_q;
  logic             tick_edge;
  logic [WIDTH-1:0] dmin_q, dmin_d;
  logic [WIDTH-1:0] dmax_q, dmax_d;
  logic [WIDTH-1:0] elapsed_q, elapsed_d;
  logic [WIDTH-1:0] elapsed_inc;
  logic             fire_q, fire_d;
  logic             fire_timeout_q, fire_timeout_d;
  logic             early_q, early_d;
  logic             param_err_q, param_err_d;

  // tick_q resets high so a tick already high at reset release is not an edge.
  assign tick_edge   = tick & ~tick_q;
  assign elapsed_inc = elapsed_q + WIDTH'(1);

  always_comb begin
    state_d        = state_q;
    dmin_d         = dmin_q;
    dmax_d         = dmax_q;
    elapsed_d      = elapsed_q;
    fire_d         = 1'b0;
    fire_timeout_d = 1'b0;
    early_d        = 1'b0;
    param_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (dmin > dmax) begin
            param_err_d = 1'b1;
          end else begin
            dmin_d    = dmin;
            dmax_d    = dmax;
            elapsed_d = '0;
            state_d   = (dmin == '0) ? WINDOW : WAIT_MIN;
          end
        end
      end

      WAIT_MIN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // Trigger is judged against the pre-increment count, so one that
          // coincides with the edge reaching dmin is still early.
          if (trigger) begin
            early_d = 1'b1;
          end
          if (tick_edge) begin
            elapsed_d = elapsed_inc;
            if (elapsed_inc == dmin_q) begin
              state_d = WINDOW;
            end
          end
        end
      end

      WINDOW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (trigger) begin
          fire_d  = 1'b1;
          state_d = IDLE;
        end else if (tick_edge) begin
          if (elapsed_q == dmax_q) begin
            fire_d         = 1'b1;
            fire_timeout_d = 1'b1;
            state_d        = IDLE;
          end else begin
            elapsed_d = elapsed_inc;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      tick_q         <= 1'b1;
      dmin_q         <= '0;
      dmax_q         <= '0;
      elapsed_q      <= '0;
      fire_q         <= 1'b0;
      fire_timeout_q <= 1'b0;
      early_q        <= 1'b0;
      param_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick;
      dmin_q         <= dmin_d;
      dmax_q         <= dmax_d;
      elapsed_q      <= elapsed_d;
      fire_q         <= fire_d;
      fire_timeout_q <= fire_timeout_d;
      early_q        <= early_d;
      param_err_q    <= param_err_d;
    end
  end

  assign busy         = (state_q == WAIT_MIN) || (state_q == WINDOW);
  assign in_window    = (state_q == WINDOW);
  assign elapsed      = elapsed_q;
  assign fire         = fire_q;
  assign fire_timeout = fire_timeout_q;
  assign early        = early_q;
  assign param_err    = param_err_q;

endmodule

// File: tb/tb_temporal_interval.sv
// Directed bench for temporal_interval (WIDTH = 8). The time base mimics a
// clock_divider with max = 4: two clocks high, two clocks low.
module tb_temporal_interval;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       trigger = 1'b0;
  logic [7:0] dmin = '0;
  logic [7:0] dmax = '0;
  logic       busy, in_window, fire, fire_timeout, early, param_err;
  logic [7:0] elapsed;

  int compared = 0;
  int mismatched = 0;
  int phase = 0;
  int rises = 0;
  int fire_seen = 0;
  int early_seen = 0;
  bit tick_run = 1'b1;

  temporal_interval #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
    .trigger(trigger), .dmin(dmin), .dmax(dmax), .busy(busy),
    .in_window(in_window), .elapsed(elapsed), .fire(fire),
    .fire_timeout(fire_timeout), .early(early), .param_err(param_err)
  );

  always #5 clk = ~clk;

  // One clock: inputs change and outputs are observed 1 ns after the edge.
  task automatic step();
    logic prev;
    @(posedge clk);
    #1;
    if (tick_run) begin
      prev  = tick;
      phase = (phase + 1) % 4;
      tick  = (phase < 2);
      if (tick && !prev) rises++;
    end
    if (fire === 1'b1) fire_seen++;
    if (early === 1'b1) early_seen++;
  endtask

  // Step until n rising edges were driven, then one more clock so the DUT
  // has acted on the last one.
  task automatic wait_edges(input int n);
    int target, guard;
    target = rises + n;
    guard  = 0;
    while (rises < target && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) begin
      compared++; mismatched++;
      $display("FAIL wait_edges timeout got %0d rises want %0d", rises, target);
    end
    step();
  endtask

  // Position the time base just after its falling edge so no edge is pending.
  task automatic align();
    int guard;
    guard = 0;
    while (phase != 2 && guard < 8) begin
      step();
      guard++;
    end
  endtask

  task automatic do_start(input logic [7:0] lo, input logic [7:0] hi);
    dmin = lo; dmax = hi; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    compared++; if ({busy, in_window, fire, fire_timeout, early, param_err} !== 6'b0) begin mismatched++; $display("FAIL reset_flags got %b want 000000", {busy, in_window, fire, fire_timeout, early, param_err}); end
    compared++; if (elapsed !== 8'd0) begin mismatched++; $display("FAIL reset_elapsed got %0d want 0", elapsed); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_trigger_in_window();
    align();
    do_start(8'd3, 8'd6);
    compared++; if ({busy, in_window} !== 2'b10) begin mismatched++; $display("FAIL t1_start busy/win got %b want 10", {busy, in_window}); end
    compared++; if (elapsed !== 8'd0) begin mismatched++; $display("FAIL t1_start_elapsed got %0d want 0", elapsed); end
    wait_edges(4);
    compared++; if ({busy, in_window, elapsed} !== {2'b11, 8'd4}) begin mismatched++; $display("FAIL t1_pre got busy/win %b elapsed %0d want 11 4", {busy, in_window}, elapsed); end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    compared++; if ({fire, fire_timeout, busy} !== 3'b100) begin mismatched++; $display("FAIL t1_fire got fire/to/busy %b want 100", {fire, fire_timeout, busy}); end
    compared++; if (elapsed !== 8'd4) begin mismatched++; $display("FAIL t1_elapsed got %0d want 4", elapsed); end
  endtask

  // Start accepted in the same cycle that fire is high.
  task automatic test_back_to_back();
    do_start(8'd0, 8'd1);
    compared++; if ({fire, busy, in_window} !== 3'b011) begin mismatched++; $display("FAIL b2b got fire/busy/win %b want 011", {fire, busy, in_window}); end
    compared++; if (elapsed !== 8'd0) begin mismatched++; $display("FAIL b2b_elapsed got %0d want 0", elapsed); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    compared++; if ({busy, fire} !== 2'b00) begin mismatched++; $display("FAIL b2b_abort got busy/fire %b want 00", {busy, fire}); end
  endtask

  task automatic test_early_then_timeout();
    int fb, eb;
    align();
    do_start(8'd3, 8'd6);
    wait_edges(1);
    fb = fire_seen;
    eb = early_seen;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    compared++; if ({early, busy, in_window, fire} !== 4'b1100) begin mismatched++; $display("FAIL t2_early got early/busy/win/fire %b want 1100", {early, busy, in_window, fire}); end
    step();
    compared++; if (early !== 1'b0) begin mismatched++; $display("FAIL t2_early_len got %b want 0", early); end
    wait_edges(5);
    compared++; if ({busy, in_window, elapsed} !== {2'b11, 8'd6}) begin mismatched++; $display("FAIL t2_at_max got busy/win %b elapsed %0d want 11 6", {busy, in_window}, elapsed); end
    wait_edges(1);
    compared++; if ({fire, fire_timeout, busy} !== 3'b110) begin mismatched++; $display("FAIL t2_timeout got fire/to/busy %b want 110", {fire, fire_timeout, busy}); end
    compared++; if (elapsed !== 8'd6) begin mismatched++; $display("FAIL t2_elapsed got %0d want 6", elapsed); end
    compared++; if (fire_seen - fb !== 1 || early_seen - eb !== 1) begin mismatched++; $display("FAIL t2_counts got fires %0d earlies %0d want 1 1", fire_seen - fb, early_seen - eb); end
    step();
    compared++; if ({fire, fire_timeout} !== 2'b00) begin mismatched++; $display("FAIL t2_fire_len got %b want 00", {fire, fire_timeout}); end
  endtask

  task automatic test_zero_window();
    int fb;
    align();
    do_start(8'd0, 8'd0);
    compared++; if ({busy, in_window, elapsed} !== {2'b11, 8'd0}) begin mismatched++; $display("FAIL t3_start got busy/win %b elapsed %0d want 11 0", {busy, in_window}, elapsed); end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    compared++; if ({fire, fire_timeout, busy, elapsed} !== {3'b100, 8'd0}) begin mismatched++; $display("FAIL t3_trig got fire/to/busy %b elapsed %0d want 100 0", {fire, fire_timeout, busy}, elapsed); end
    align();
    fb = fire_seen;
    do_start(8'd0, 8'd0);
    wait_edges(1);
    compared++; if ({fire, fire_timeout, busy, elapsed} !== {3'b110, 8'd0}) begin mismatched++; $display("FAIL t3_timeout got fire/to/busy %b elapsed %0d want 110 0", {fire, fire_timeout, busy}, elapsed); end
    compared++; if (fire_seen - fb !== 1) begin mismatched++; $display("FAIL t3_fire_count got %0d want 1", fire_seen - fb); end
  endtask

  task automatic test_param_err();
    int fb;
    fb = fire_seen;
    do_start(8'd5, 8'd2);
    compared++; if ({param_err, busy} !== 2'b10) begin mismatched++; $display("FAIL t4_err got perr/busy %b want 10", {param_err, busy}); end
    step();
    compared++; if ({param_err, busy} !== 2'b00) begin mismatched++; $display("FAIL t4_err_len got perr/busy %b want 00", {param_err, busy}); end
    compared++; if (fire_seen != fb) begin mismatched++; $display("FAIL t4_no_fire got %0d fires want 0", fire_seen - fb); end
  endtask

  task automatic test_abort_and_ignored_start();
    int fb;
    align();
    do_start(8'd2, 8'd9);
    wait_edges(2);
    dmin = 8'd0; dmax = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    compared++; if ({busy, in_window, elapsed} !== {2'b11, 8'd2}) begin mismatched++; $display("FAIL t5_busy_start got busy/win %b elapsed %0d want 11 2", {busy, in_window}, elapsed); end
    wait_edges(1);
    compared++; if (elapsed !== 8'd3) begin mismatched++; $display("FAIL t5_elapsed3 got %0d want 3", elapsed); end
    fb = fire_seen;
    abort = 1'b1; trigger = 1'b1;
    step();
    abort = 1'b0; trigger = 1'b0;
    compared++; if ({fire, busy, early, elapsed} !== {3'b000, 8'd3}) begin mismatched++; $display("FAIL t5_abort got fire/busy/early %b elapsed %0d want 000 3", {fire, busy, early}, elapsed); end
    wait_edges(1);
    compared++; if (fire_seen != fb || elapsed !== 8'd3) begin mismatched++; $display("FAIL t5_after got fires %0d elapsed %0d want 0 3", fire_seen - fb, elapsed); end
  endtask

  task automatic test_mid_reset();
    int fb;
    align();
    do_start(8'd2, 8'd9);
    wait_edges(4);
    compared++; if (elapsed !== 8'd4) begin mismatched++; $display("FAIL t6_pre got %0d want 4", elapsed); end
    fb = fire_seen;
    tick_run = 1'b0; tick = 1'b1; rst = 1'b1;
    step();
    compared++; if ({busy, in_window, fire, fire_timeout, early, param_err} !== 6'b0 || elapsed !== 8'd0) begin mismatched++; $display("FAIL t6_reset got flags %b elapsed %0d want 000000 0", {busy, in_window, fire, fire_timeout, early, param_err}, elapsed); end
    rst = 1'b0;
    step();
    do_start(8'd2, 8'd9);
    step(); step(); step();
    compared++; if ({busy, elapsed} !== {1'b1, 8'd0}) begin mismatched++; $display("FAIL t6_tick_held got busy %b elapsed %0d want 1 0", busy, elapsed); end
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    step();
    compared++; if (elapsed !== 8'd1) begin mismatched++; $display("FAIL t6_new_edge got %0d want 1", elapsed); end
    compared++; if (fire_seen != fb) begin mismatched++; $display("FAIL t6_no_fire got %0d fires want 0", fire_seen - fb); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trigger_in_window();
    test_back_to_back();
    test_early_then_timeout();
    test_zero_window();
    test_param_err();
    test_abort_and_ignored_start();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/temporal_interval.md
# temporal_interval

Timed-interval unit for the Interactive Scores engine, directly downstream of `clock_divider`. It consumes the divided time-base clock (`out_clk`), counts its rising edges as time units, and resolves one score interval of flexible duration [dmin, dmax]. The interval ends on an interactive trigger arriving inside the window, or by timeout at dmax. One instance models one temporal relation between two score events.

## Interface
- `WIDTH`, default 32: width of the duration bounds and of the elapsed counter, in ticks.
- `clk` in 1: system clock, same clock that drives `clock_divider`.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: time base, connected to `clock_divider.out_clk` (level signal, synchronous to `clk`).
- `start` in 1: one-cycle request to begin an interval; honoured only in IDLE.
- `abort` in 1: cancels a running interval; no `fire` is produced.
- `trigger` in 1: interactive event, one-cycle pulse.
- `dmin` in WIDTH: minimum duration in ticks, sampled on accepted `start`.
- `dmax` in WIDTH: maximum duration in ticks, sampled on accepted `start`.
- `busy` out 1: interval running (WAIT_MIN or WINDOW).
- `in_window` out 1: state is WINDOW.
- `elapsed` out WIDTH: ticks counted since start. Holds its final value after completion.
- `fire` out 1: one-cycle pulse when the interval ends (trigger or timeout).
- `fire_timeout` out 1: qualifies `fire`. 1 means ended by timeout. It is 0 whenever `fire` = 0.
- `early` out 1: one-cycle pulse when a trigger arrives in WAIT_MIN; that trigger is discarded.
- `param_err` out 1: one-cycle pulse when `start` is seen in IDLE with dmin > dmax; the start is rejected.

## Operation
- Tick edge detection uses a registered copy `tick_q`. `tick_edge = tick & ~tick_q`. `tick_q` resets to 1, so a `tick` that is high at reset release produces no edge.
- The FSM has three states: IDLE, WAIT_MIN, WINDOW. All outputs are registered.
- IDLE:
  - `start` with dmin ≤ dmax: latch the bounds, clear `elapsed`, then go to WINDOW if dmin = 0, otherwise to WAIT_MIN.
  - `start` with dmin > dmax: pulse `param_err` and stay in IDLE.
  - Triggers are ignored. No `early` pulse is produced in IDLE.
- WAIT_MIN:
  - On `tick_edge`, `elapsed` increments by 1.
  - When the new value equals the latched dmin, go to WINDOW.
  - A `trigger` pulses `early` and is discarded. The trigger is judged against the pre-increment `elapsed`, so a trigger coincident with the edge that reaches dmin is still early.
- WINDOW (accepts triggers for dmin ≤ elapsed ≤ dmax, inclusive):
  - `trigger`: pulse `fire`, `fire_timeout` = 0, go to IDLE. `elapsed` freezes.
  - `tick_edge` with no trigger and elapsed < dmax: increment `elapsed`.
  - `tick_edge` with no trigger and elapsed = dmax: pulse `fire`, `fire_timeout` = 1, go to IDLE. `elapsed` stays at dmax and never exceeds it.
  - Trigger and tick edge in the same cycle: the trigger wins.
- `abort` in WAIT_MIN or WINDOW: go to IDLE with no `fire` and no `early`; `elapsed` freezes. `abort` takes priority over `trigger` and timeout. `abort` in IDLE has no effect.
- `start` while busy is ignored. There is no restart; the current interval continues unchanged.
- Changes to `dmin`/`dmax` while busy have no effect; only the latched copies are used.
- Arithmetic: `elapsed` is unsigned WIDTH bits. It cannot wrap, because it saturates at the latched dmax < 2^WIDTH.

## Timing
- Reset values: state IDLE, `busy` 0, `in_window` 0, `elapsed` 0, `fire` 0, `fire_timeout` 0, `early` 0, `param_err` 0, `tick_q` 1.
- `start` accepted in cycle n: `busy` = 1 and `elapsed` = 0 in cycle n+1. If dmin = 0, `in_window` = 1 in n+1 and a trigger in n+1 is accepted.
- `tick` rising between cycles n-1 and n: `tick_edge` is seen in cycle n, and `elapsed` or the state updates in n+1.
- Trigger in WINDOW at cycle n: `fire` = 1 and `busy` = 0 in n+1; `fire` = 0 in n+2.
- `early` and `param_err` appear one cycle after their cause and last exactly one cycle.
- Sustained throughput: a `start` in the same cycle that `fire` is high is accepted.
- `rst` asserted mid-interval: all outputs return to reset values on the next edge, and no `fire` is produced.

## Test plan
Common setup: WIDTH = 8; `tick` from a `clock_divider` with max = 4 (2 clocks high, 2 low).
- dmin = 3, dmax = 6, trigger after the 4th tick edge -> `fire` = 1, `fire_timeout` = 0, `elapsed` = 4, `busy` drops in the same cycle as `fire`.
- dmin = 3, dmax = 6, trigger at elapsed = 1, then no trigger -> `early` pulses once; then `fire` with `fire_timeout` = 1 on the 7th tick edge; `elapsed` = 6.
- dmin = 0, dmax = 0, trigger in the cycle after start -> `fire`, `fire_timeout` = 0, `elapsed` = 0. Second run without a trigger -> timeout on the first tick edge.
- dmin = 5, dmax = 2 -> `param_err` pulses one cycle, `busy` stays 0, no `fire`.
- dmin = 2, dmax = 9: `abort` at elapsed = 3 coincident with a trigger -> no `fire`, `busy` 0, `elapsed` = 3. A `start` while busy is ignored (`elapsed` is not cleared).
- `rst` asserted at elapsed = 4 of dmin = 2, dmax = 9 -> all outputs 0 next cycle. With `tick` high at reset release -> `elapsed` does not increment until the next rising edge.
